// File: rtl/sync_fifo_flags.sv
// Single-clock FIFO with registered status flags, occupancy count and sticky
// overflow/underflow errors. Define FWFT_EN for first-word fall-through reads.
module sync_fifo_flags #(
  parameter int DEPTH      = 8,
  parameter int DATA_WIDTH = 8,
  parameter int AF_LEVEL   = 6,
  parameter int AE_LEVEL   = 2,
  parameter int PTR_WIDTH  = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  w_en,
  input  logic                  r_en,
  input  logic                  err_clr,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [PTR_WIDTH:0]    count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int CW = PTR_WIDTH + 1;
  localparam logic [PTR_WIDTH:0] LP_DEPTH = CW'(DEPTH);
  localparam logic [PTR_WIDTH:0] LP_AF    = CW'(AF_LEVEL);
  localparam logic [PTR_WIDTH:0] LP_AE    = CW'(AE_LEVEL);

  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
    $fatal(1, "sync_fifo_flags: DEPTH must be a power of two >= 2");
  end
  if ((AF_LEVEL < 1) || (AF_LEVEL > DEPTH)) begin : g_bad_af
    $fatal(1, "sync_fifo_flags: AF_LEVEL out of range 1..DEPTH");
  end
  if ((AE_LEVEL < 0) || (AE_LEVEL > DEPTH - 1)) begin : g_bad_ae
    $fatal(1, "sync_fifo_flags: AE_LEVEL out of range 0..DEPTH-1");
  end

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_WIDTH:0]    r_wptr;
  logic [PTR_WIDTH:0]    r_rptr;
  logic [PTR_WIDTH:0]    r_count;
  logic                  r_full;
  logic                  r_empty;
  logic                  r_af;
  logic                  r_ae;
  logic                  r_ovf;
  logic                  r_udf;

  logic                  w_wr_acc;
  logic                  w_rd_acc;
  logic [PTR_WIDTH:0]    w_count_nxt;
  logic [PTR_WIDTH-1:0]  w_waddr;
  logic [PTR_WIDTH-1:0]  w_raddr;

  // Acceptance uses the flags registered at the start of the cycle.
  assign w_wr_acc = w_en & ~r_full;
  assign w_rd_acc = r_en & ~r_empty;
  assign w_waddr  = r_wptr[PTR_WIDTH-1:0];
  assign w_raddr  = r_rptr[PTR_WIDTH-1:0];

  always_comb begin
    w_count_nxt = r_count;
    case ({w_wr_acc, w_rd_acc})
      2'b10:   w_count_nxt = r_count + 1'b1;
      2'b01:   w_count_nxt = r_count - 1'b1;
      default: w_count_nxt = r_count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_wr_acc) begin
      r_mem[w_waddr] <= data_in;
    end
  end

  // Pointers carry one extra bit and wrap modulo 2*DEPTH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_full  <= 1'b0;
      r_empty <= 1'b1;
      r_af    <= 1'b0;
      r_ae    <= 1'b1;
      r_ovf   <= 1'b0;
      r_udf   <= 1'b0;
    end else begin
      if (w_wr_acc) r_wptr <= r_wptr + 1'b1;
      if (w_rd_acc) r_rptr <= r_rptr + 1'b1;
      r_count <= w_count_nxt;
      r_full  <= (w_count_nxt == LP_DEPTH);
      r_empty <= (w_count_nxt == '0);
      r_af    <= (w_count_nxt >= LP_AF);
      r_ae    <= (w_count_nxt <= LP_AE);
      // A new error in the same cycle as err_clr keeps the flag set.
      if (w_en & r_full)    r_ovf <= 1'b1;
      else if (err_clr)     r_ovf <= 1'b0;
      if (r_en & r_empty)   r_udf <= 1'b1;
      else if (err_clr)     r_udf <= 1'b0;
    end
  end

`ifdef FWFT_EN
  assign data_out = r_mem[w_raddr];
`else
  logic [DATA_WIDTH-1:0] r_dout;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dout <= '0;
    end else if (w_rd_acc) begin
      r_dout <= r_mem[w_raddr];
    end
  end

  assign data_out = r_dout;
`endif

  assign full         = r_full;
  assign empty        = r_empty;
  assign almost_full  = r_af;
  assign almost_empty = r_ae;
  assign count        = r_count;
  assign overflow     = r_ovf;
  assign underflow    = r_udf;

endmodule
